// File: rtl/groestl_feed_pkg.sv
// Shared types and helpers for the Groestl message feeder.
// Holds word/half widths, the message word layout and the byte-reversal helper.
package groestl_feed_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned HALF_W = 32;

  // Message word as presented to the core: high half in bits 63:32.
  typedef struct packed {
    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
  } word_t;

  function automatic logic [HALF_W-1:0] bswap32(input logic [HALF_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/groestl_word_fifo.sv
// Generic first-word-fall-through FIFO on a register array.
// Push is qualified against the pre-pop level, so a full FIFO drops a same-cycle push.
module groestl_word_fifo
  import groestl_feed_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned W     = WORD_W,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_flush;
  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_flush   = reset | i_clear;
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_push_ok = i_push & ~w_full;
  assign w_pop_ok  = i_pop & ~w_empty;

  // Pointers wrap naturally; level is tracked separately to tell full from empty.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is never flushed; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (!w_flush && w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/groestl_src_fifo.sv
// Host-to-core feeder: assembles 32-bit halves into 64-bit words and buffers them.
// Presents an active-low src_ready / src_read source interface with sticky error flags.
module groestl_src_fifo
  import groestl_feed_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              half_valid,
  input  logic              half_sel,
  input  logic              half_swap,
  input  logic [HALF_W-1:0] half_data,
  output logic              full,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic              underflow,
  output logic              src_ready,
  input  logic              src_read,
  output logic [WORD_W-1:0] din
);

  logic [HALF_W-1:0] r_lo_hold;
  logic              r_overflow;
  logic              r_underflow;

  logic [HALF_W-1:0] w_half;
  logic              w_lo_wr;
  logic              w_commit;
  word_t             w_word;
  word_t             w_head;
  logic [LW-1:0]     w_level;
  logic              w_full;
  logic              w_empty;

  assign w_half   = half_swap ? bswap32(half_data) : half_data;
  assign w_lo_wr  = half_valid & ~half_sel;
  assign w_commit = half_valid & half_sel;
  assign w_word   = '{hi: w_half, lo: r_lo_hold};

  // Low half is retained across commits so repeated high writes reuse it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_lo_hold <= '0;
    end else if (w_lo_wr) begin
      r_lo_hold <= w_half;
    end
  end

  // Sticky error flags, cleared only by reset or clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_commit && w_full)  r_overflow  <= 1'b1;
      if (src_read && w_empty) r_underflow <= 1'b1;
    end
  end

  groestl_word_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (clear),
    .i_push  (w_commit),
    .i_wdata (w_word),
    .i_pop   (src_read),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign din       = w_head;
  assign level     = w_level;
  assign full      = w_full;
  assign src_ready = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_groestl_src_fifo.sv
// Directed and randomized bench for groestl_src_fifo against a queue-based model.
module tb_groestl_src_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          half_valid;
  logic          half_sel;
  logic          half_swap;
  logic [31:0]   half_data;
  logic          full;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;
  logic          src_ready;
  logic          src_read;
  logic [63:0]   din;

  groestl_src_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .half_valid (half_valid),
    .half_sel   (half_sel),
    .half_swap  (half_swap),
    .half_data  (half_data),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .underflow  (underflow),
    .src_ready  (src_ready),
    .src_read   (src_read),
    .din        (din)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: plain queue of words plus the pending low half and flags.
  logic [63:0] mq[$];
  logic [31:0] m_lo;
  logic        m_ov;
  logic        m_un;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    mq.delete();
    m_lo = 32'h0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic model_step(input logic hv, input logic hs, input logic sw,
                            input logic [31:0] d, input logic rd, input logic clr);
    logic [31:0] h;
    int          n;
    if (clr) begin
      model_flush();
      return;
    end
    h = sw ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
    n = mq.size();
    if (rd) begin
      if (n == 0) m_un = 1'b1;
      else void'(mq.pop_front());
    end
    if (hv && hs) begin
      if (n == int'(DEPTH)) m_ov = 1'b1;
      else mq.push_back({h, m_lo});
    end
    if (hv && !hs) m_lo = h;
  endtask

  task automatic compare_all();
    logic [63:0] head;
    head = (mq.size() != 0) ? mq[0] : 64'h0;
    check("din",       din,       head);
    check("level",     64'(level), 64'(mq.size()));
    check("src_ready", 64'(src_ready), 64'(mq.size() == 0));
    check("full",      64'(full),  64'(mq.size() == int'(DEPTH)));
    check("overflow",  64'(overflow),  64'(m_ov));
    check("underflow", 64'(underflow), 64'(m_un));
  endtask

  // One clock: drive at negedge, sampled at posedge, checked at the next negedge.
  task automatic cycle(input logic hv, input logic hs, input logic sw,
                       input logic [31:0] d, input logic rd, input logic clr);
    half_valid = hv;
    half_sel   = hs;
    half_swap  = sw;
    half_data  = d;
    src_read   = rd;
    clear      = clr;
    @(posedge clk);
    model_step(hv, hs, sw, d, rd, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    half_valid = 1'b0; half_sel = 1'b0; half_swap = 1'b0;
    half_data = 32'h0; src_read = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_flush();
    compare_all();
  endtask

  task automatic push_word(input logic [63:0] w, input logic rd);
    cycle(1'b1, 1'b0, 1'b0, w[31:0], 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, w[63:32], rd, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_src_ready", 64'(src_ready), 64'h1);
    check("rst_din",       din, 64'h0);
    check("rst_level",     64'(level), 64'h0);

    // Basic push then pop.
    cycle(1'b1, 1'b0, 1'b0, 32'h33221100, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h77665544, 1'b0, 1'b0);
    check("basic_din",   din, 64'h7766554433221100);
    check("basic_ready", 64'(src_ready), 64'h0);
    check("basic_level", 64'(level), 64'h1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("pop_ready", 64'(src_ready), 64'h1);
    check("pop_din",   din, 64'h0);

    // Byte swap on both halves.
    cycle(1'b1, 1'b0, 1'b1, 32'h00112233, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h44556677, 1'b0, 1'b0);
    check("swap_din", din, 64'h7766554433221100);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Fill to full, drop one, drain in order.
    for (int i = 0; i <= int'(DEPTH); i++) begin
      push_word({32'hA000_0000 | 32'(i), 32'(i)}, 1'b0);
      if (i == int'(DEPTH) - 1) check("fill_full", 64'(full), 64'h1);
    end
    check("fill_overflow", 64'(overflow), 64'h1);
    check("fill_level",    64'(level), 64'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("drain_order", din, {32'hA000_0000 | 32'(i), 32'(i)});
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("drain_underflow", 64'(underflow), 64'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Wrap-around at steady level 3.
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 40; i++) push_word({$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap_level", 64'(level), 64'h0);
    check("wrap_ov",    64'(overflow), 64'h0);
    check("wrap_un",    64'(underflow), 64'h0);

    // Pop while empty.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("empty_pop_un",    64'(underflow), 64'h1);
    check("empty_pop_level", 64'(level), 64'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Push and pop together at full.
    for (int i = 0; i < int'(DEPTH); i++) push_word({32'(i + 100), 32'(i)}, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("full_pp_level", 64'(level), 64'(DEPTH - 1));
    check("full_pp_ov",    64'(overflow), 64'h1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Clear overrides a same-cycle commit and discards the pending low half.
    for (int i = 0; i < 5; i++) push_word({$urandom, $urandom}, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h5555_5555, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'hAAAA_AAAA, 1'b0, 1'b1);
    check("clr_level", 64'(level), 64'h0);
    check("clr_ov",    64'(overflow), 64'h0);
    check("clr_un",    64'(underflow), 64'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    check("clr_next_din", din, 64'h0000_0001_0000_0000);

    // Randomized traffic with occasional clear and one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      logic rd;
      rd = (mq.size() != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, rd, ($urandom_range(0, 63) == 0));
      if (i == 200) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
